// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers the PC register (advance / hold / redirect), runs the
// instruction-memory req/ack handshake and keeps a one-entry IF/ID buffer.
module fetch_sequencer #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [31:0]           PCResult,
  output logic [31:0]           Address,
  output logic                  flush,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid,
  input  logic                  id_ready,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_target
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_ADVANCE  = 2'd0,
    CMD_HOLD     = 2'd1,
    CMD_REDIRECT = 2'd2
  } cmd_t;

  state_t                state_r;
  state_t                state_nxt_s;
  cmd_t                  cmd_s;
  logic [31:0]           redir_addr_s;
  logic [31:0]           pend_target_r;
  logic [31:0]           pend_nxt_s;
  logic                  req_s;
  logic                  load_s;
  logic                  clear_s;
  logic [DATA_WIDTH-1:0] instr_out_r;
  logic [31:0]           instr_pc_r;
  logic                  instr_valid_r;

  // Next-state, PC command and buffer control decode
  always_comb begin
    state_nxt_s  = state_r;
    cmd_s        = CMD_HOLD;
    redir_addr_s = redirect_target;
    pend_nxt_s   = pend_target_r;
    req_s        = 1'b0;
    load_s       = 1'b0;
    clear_s      = 1'b0;
    if (Rst) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          req_s = (!instr_valid_r || id_ready) && !redirect_valid;
          if (redirect_valid) begin
            cmd_s   = CMD_REDIRECT;
            clear_s = 1'b1;
          end else if (req_s && imem_ack) begin
            cmd_s  = CMD_ADVANCE;
            load_s = 1'b1;
          end else if (req_s) begin
            state_nxt_s = ST_WAIT;
          end else begin
            cmd_s = CMD_HOLD;
          end
        end
        ST_WAIT: begin
          req_s = 1'b1;
          if (redirect_valid) begin
            clear_s = 1'b1;
            if (imem_ack) begin
              cmd_s       = CMD_REDIRECT;
              state_nxt_s = ST_RUN;
            end else begin
              pend_nxt_s  = redirect_target;
              state_nxt_s = ST_SQUASH;
            end
          end else if (imem_ack) begin
            cmd_s       = CMD_ADVANCE;
            load_s      = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            cmd_s = CMD_HOLD;
          end
        end
        ST_SQUASH: begin
          // A redirect arriving during the squash replaces the parked target.
          req_s = 1'b1;
          if (redirect_valid) begin
            clear_s    = 1'b1;
            pend_nxt_s = redirect_target;
          end else begin
            clear_s = 1'b0;
          end
          if (imem_ack) begin
            cmd_s        = CMD_REDIRECT;
            redir_addr_s = redirect_valid ? redirect_target : pend_target_r;
            state_nxt_s  = ST_RUN;
          end else begin
            cmd_s = CMD_HOLD;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = PCResult;
  assign Address     = (cmd_s == CMD_REDIRECT) ? redir_addr_s : (PCResult + PC_STEP);
  assign flush       = (cmd_s == CMD_HOLD);
  assign instr_out   = instr_out_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;

  // FSM state and parked redirect target
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r       <= ST_RUN;
      pend_target_r <= 32'd0;
    end else begin
      state_r       <= state_nxt_s;
      pend_target_r <= pend_nxt_s;
    end
  end

  // IF/ID buffer: redirect clears, fresh data loads, decode handshake drains
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      instr_out_r   <= {DATA_WIDTH{1'b0}};
      instr_pc_r    <= 32'd0;
      instr_valid_r <= 1'b0;
    end else if (clear_s) begin
      instr_valid_r <= 1'b0;
    end else if (load_s) begin
      instr_out_r   <= imem_rdata;
      instr_pc_r    <= PCResult;
      instr_valid_r <= 1'b1;
    end else if (instr_valid_r && id_ready) begin
      instr_valid_r <= 1'b0;
    end else begin
      instr_valid_r <= instr_valid_r;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: PC register and memory modelled here,
// delivered instructions checked against a scoreboard queue at the decode side.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] PCResult;
  logic [31:0] Address;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [63:0] sb_q[$];

  fetch_sequencer #(.DATA_WIDTH(32), .PC_STEP(32'd4)) dut (
    .Clk(Clk), .Rst(Rst), .PCResult(PCResult), .Address(Address), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target)
  );

  always #5 Clk = ~Clk;

  // PC register as the sequencer sees it
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) PCResult <= 32'd0;
    else     PCResult <= flush ? (Address - 32'd4) : Address;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Decode side: every accepted instruction must match the oldest expectation
  always @(negedge Clk) begin
    if (!Rst && instr_valid && id_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check_eq("sb_pc", instr_pc, e[63:32]);
        check_eq("sb_data", instr_out, e[31:0]);
      end
    end
  end

  task automatic drive(input logic ack, input logic rdy, input logic rv, input logic [31:0] tgt);
    imem_ack        = ack;
    id_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_rdata      = mem_word(PCResult);
    @(negedge Clk);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch_ok(input logic [31:0] pc);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
    check_eq("fetch_addr", imem_addr, pc);
    check_eq("fetch_flush", {31'd0, flush}, 32'd0);
    check_eq("fetch_next", Address, pc + 32'd4);
    sb_q.push_back({pc, mem_word(pc)});
    tick();
    check_eq("fetch_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("fetch_ipc", instr_pc, pc);
    check_eq("fetch_pc", PCResult, pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; imem_ack = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'd0; imem_rdata = 32'd0;
    @(negedge Clk);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_flush", {31'd0, flush}, 32'd1);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_iout", instr_out, 32'd0);
    check_eq("rst_ipc", instr_pc, 32'd0);
    tick();
    Rst = 1'b0;

    for (int i = 0; i < 3; i++) fetch_ok(32'(i * 4));

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("stall_req", {31'd0, imem_req}, 32'd0);
      check_eq("stall_flush", {31'd0, flush}, 32'd1);
      tick();
      check_eq("stall_pc", PCResult, 32'h0000_000C);
      check_eq("stall_ipc", instr_pc, 32'h0000_0008);
      check_eq("stall_iout", instr_out, mem_word(32'h0000_0008));
      check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    fetch_ok(32'h0000_000C);

    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0);
      check_eq("wait_req", {31'd0, imem_req}, 32'd1);
      check_eq("wait_flush", {31'd0, flush}, 32'd1);
      tick();
      check_eq("wait_pc", PCResult, 32'h0000_0010);
    end
    fetch_ok(32'h0000_0010);

    drive(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    check_eq("rdw_req", {31'd0, imem_req}, 32'd1);
    check_eq("rdw_flush", {31'd0, flush}, 32'd1);
    tick();
    check_eq("rdw_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rdw_pc_hold", PCResult, 32'h0000_0014);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("sq_req", {31'd0, imem_req}, 32'd1);
    check_eq("sq_flush", {31'd0, flush}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    check_eq("sq_exit_addr", Address, 32'h0000_0100);
    check_eq("sq_exit_flush", {31'd0, flush}, 32'd0);
    tick();
    check_eq("sq_exit_pc", PCResult, 32'h0000_0100);
    check_eq("sq_exit_valid", {31'd0, instr_valid}, 32'd0);

    drive(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check_eq("ackrd_addr", Address, 32'h0000_0040);
    check_eq("ackrd_flush", {31'd0, flush}, 32'd0);
    tick();
    check_eq("ackrd_pc", PCResult, 32'h0000_0040);
    check_eq("ackrd_valid", {31'd0, instr_valid}, 32'd0);

    drive(1'b0, 1'b1, 1'b1, 32'h0000_0080);
    check_eq("run_rd_req", {31'd0, imem_req}, 32'd0);
    check_eq("run_rd_addr", Address, 32'h0000_0080);
    tick();
    check_eq("run_rd_pc", PCResult, 32'h0000_0080);
    fetch_ok(32'h0000_0080);

    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_valid", {31'd0, instr_valid}, 32'd0);
    fetch_ok(32'hFFFF_FFFC);

    drive(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    imem_ack = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check_eq("arst_req", {31'd0, imem_req}, 32'd0);
    check_eq("arst_flush", {31'd0, flush}, 32'd1);
    check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("arst_pc", PCResult, 32'd0);
    tick();
    Rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    check_eq("post_rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("post_rst_addr", Address, 32'h0000_0200);
    tick();
    check_eq("post_rst_pc", PCResult, 32'h0000_0200);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Drives the `Address`/`flush` inputs of the program counter and consumes its `PCResult` output.
- Each cycle it decides whether the PC advances, holds, or redirects to a branch target.
- It runs the instruction-memory request/acknowledge handshake and holds the fetched instruction in a one-entry IF/ID buffer with a valid/ready handshake toward decode.
- It sits between the PC register, instruction memory and the decode stage.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: instruction word width.
- `PC_STEP`, default 4: byte increment per sequential instruction.

Ports:
- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: asynchronous, active-high reset.
- `PCResult`  in  32: current PC register value.
- `Address`  out  32: next-PC value presented to the PC register (combinational).
- `flush`  out  1: when 1, the PC loads `Address - 4` (combinational); used to hold the PC.
- `imem_req`  out  1: instruction-memory request (combinational).
- `imem_addr`  out  32: equals `PCResult`.
- `imem_ack`  in  1: memory has returned data this cycle.
- `imem_rdata`  in  DATA_WIDTH: instruction word, valid when `imem_ack` = 1.
- `instr_out`  out  DATA_WIDTH: buffered instruction (registered).
- `instr_pc`  out  32: PC of `instr_out` (registered).
- `instr_valid`  out  1: buffer holds an instruction (registered).
- `id_ready`  in  1: decode accepts the buffer this cycle when `instr_valid` = 1.
- `redirect_valid`  in  1: single-cycle pulse for a taken branch or jump.
- `redirect_target`  in  32: branch target, sampled when `redirect_valid` = 1.

## Operation
- **PC command encoding:**
  - Advance: `Address = PCResult + PC_STEP`, `flush = 0`.
  - Hold: `Address = PCResult + PC_STEP`, `flush = 1`, so the PC reloads `PCResult`.
  - Redirect: `Address = target`, `flush = 0`.
- **FSM states:**
  - RUN: no request outstanding.
  - WAIT: request outstanding, result wanted.
  - SQUASH: request outstanding, result to be discarded.
- **`imem_req`:**
  - Asserted in WAIT and SQUASH.
  - Asserted in RUN when `(!instr_valid || id_ready) && !redirect_valid`.
  - Once asserted, it stays high with `imem_addr` stable until `imem_ack`.
- **RUN/WAIT, `imem_req` = 1, `imem_ack` = 1, no redirect:**
  - `instr_out <= imem_rdata`, `instr_pc <= PCResult`, `instr_valid <= 1`.
  - PC command is Advance; next state is RUN.
- **RUN/WAIT, `imem_req` = 1, no ack, no redirect:** PC command is Hold; next state is WAIT.
- **RUN, `imem_req` = 0, no redirect:** PC command is Hold.
- **Buffer consumption:** `instr_valid && id_ready` with no new ack clears `instr_valid` next edge.
- **Redirect, in any state:** the buffer is cleared (`instr_valid <= 0`), regardless of `id_ready`.
  - RUN: PC command is Redirect (`redirect_target`); state stays RUN.
  - WAIT with ack in the same cycle: data is discarded, PC command is Redirect; next state is RUN.
  - WAIT without ack: `pend_target <= redirect_target`, PC command is Hold; next state is SQUASH.
  - SQUASH: `pend_target` is overwritten; the latest redirect wins.
- **SQUASH exit:**
  - On `imem_ack`, data is discarded and PC command is Redirect (`pend_target`, or `redirect_target` if `redirect_valid` is also high).
  - Next state is RUN.
- **SQUASH without ack:** PC command is Hold.
- **Arithmetic:** all PC arithmetic is 32-bit modulo 2^32; `0xFFFFFFFC + 4 = 0x00000000`.

## Timing
- **Reset values:**
  - State RUN; `instr_valid` = 0, `instr_out` = 0, `instr_pc` = 0, `pend_target` = 0.
  - While `Rst` is high, `imem_req` = 0 and the PC command is Hold.
- **Reset mid-transaction:** reset abandons any outstanding request.
- **Combinational paths:** `Address`, `flush` and `imem_req` depend combinationally on `PCResult`, the FSM state, `imem_ack`, `redirect_valid` and `id_ready`. There is no combinational path from `imem_rdata`.
- **Latency:** `imem_ack` at edge N gives `instr_valid` = 1 after edge N, and the PC shows the next address after edge N.
- **Throughput:** with zero-wait memory and `id_ready` held high, one instruction per cycle.
- **Redirect latency:** in RUN, the PC equals the target one edge after the redirect and `imem_req` is asserted for the target that cycle.

## Test plan
- **Reset, then zero-wait fetch:** PC = 0x0, `imem_ack` = 1 every cycle, `id_ready` = 1 → `instr_pc` = 0x0, 0x4, 0x8 on consecutive cycles; `instr_valid` stays 1.
- **Decode stall:** `id_ready` = 0 for 3 cycles with the buffer full → `imem_req` = 0, `flush` = 1, PC and `instr_out` unchanged; `id_ready` = 1 → fetch resumes the same cycle.
- **Memory wait states:** ack delayed 2 cycles at PC = 0x10 → `imem_req` high for 3 cycles, `flush` = 1 for 2 cycles, then `instr_pc` = 0x10 and the PC becomes 0x14.
- **Redirect in WAIT:** redirect to 0x100 in the first wait cycle, ack 2 cycles later → data discarded, `instr_valid` = 0, PC becomes 0x100 on the edge of the ack.
- **Simultaneous ack and redirect:** redirect to 0x40 with ack in the same cycle → `instr_valid` = 0, PC = 0x40, no instruction delivered.
- **Wrap and async reset:** PC = 0xFFFFFFFC with ack → next PC = 0x0; `Rst` asserted mid-WAIT → `imem_req` drops immediately, `instr_valid` = 0 and state RUN after release.
